lfsr_rng: RTL and testbench

- Parametrised Fibonacci LFSR random-number generator; successor to the fixed 8-bit seeded LFSR.
- Adds configurable width and taps, zero-seed lockup guard, and a request/response port returning a uniform value in [0, bound-1] via rejection sampling.
- Sits between game-control logic (spawn position, item type) and the free-running entropy source.

---
 rtl/lfsr_rng.sv | 146 ++++++++++++++
 tb/tb_lfsr_rng.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng.sv
// Parametrised Fibonacci LFSR random-number generator with a zero-seed
// lockup guard and a request/response port that returns a uniform value
// in [0, bound-1] using rejection sampling with a bounded fallback.
module lfsr_rng #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   TAPS      = 8'hB8,
  parameter logic [WIDTH-1:0]   RST_SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int                 MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_bound,
  output logic             req_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] state_out
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  // A zero seed would lock the register up, so it is promoted to 1.
  localparam logic [WIDTH-1:0] RST_VAL = (RST_SEED == '0) ? ONE : RST_SEED;
  localparam int               TW      = $clog2(MAX_TRIES) + 1;
  localparam logic [TW-1:0]    TRY_LAST = TW'(MAX_TRIES - 1);
  localparam logic [TW-1:0]    TRY_ONE  = TW'(1);

  typedef enum logic [1:0] {IDLE, DRAW, RESP} fsm_t;

  fsm_t             fsm;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] bound_q;
  logic [WIDTH-1:0] mask_q;
  logic [TW-1:0]    tries;
  logic             accept;
  logic [WIDTH-1:0] accept_val;
  logic [WIDTH-1:0] cand;

  // One Fibonacci step: XOR of the tapped bits shifts in at the LSB.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic fb;
    fb = ^(s & TAPS);
    return {s[WIDTH-2:0], fb};
  endfunction

  // Smallest 2^k-1 covering bound-1: smear the highest set bit of bound-1
  // down to bit 0. bound==0 yields all-ones, bound==1 yields zero; both are
  // special-cased in the draw logic anyway.
  function automatic logic [WIDTH-1:0] range_mask(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] m;
    m = b - ONE;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      m[i] = m[i] | m[i+1];
    end
    return m;
  endfunction

  assign state_out = state;
  assign cand      = state & mask_q;

  // Decide whether the current draw is accepted and what value it yields.
  always_comb begin
    accept     = 1'b0;
    accept_val = '0;
    if (bound_q == '0) begin
      accept     = 1'b1;
      accept_val = state;
    end else if (bound_q == ONE) begin
      accept     = 1'b1;
      accept_val = '0;
    end else if (cand < bound_q) begin
      accept     = 1'b1;
      accept_val = cand;
    end else if (tries == TRY_LAST) begin
      // Out of retries: fold the candidate back into range; cand >= bound here.
      accept     = 1'b1;
      accept_val = cand - bound_q;
    end
  end

  // LFSR state: load wins, DRAW always steps, otherwise step on en.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= RST_VAL;
    end else if (load) begin
      state <= (seed == '0) ? ONE : seed;
    end else if (fsm == DRAW || en) begin
      state <= lfsr_step(state);
    end
  end

  // Request/response controller with registered handshake outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      fsm       <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tries     <= '0;
      bound_q   <= '0;
      mask_q    <= '0;
    end else if (load) begin
      // A reseed abandons any draw or pending response.
      fsm       <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (req_valid) begin
            bound_q   <= req_bound;
            mask_q    <= range_mask(req_bound);
            tries     <= '0;
            req_ready <= 1'b0;
            fsm       <= DRAW;
          end
        end
        DRAW: begin
          if (accept) begin
            rsp_data  <= accept_val;
            rsp_valid <= 1'b1;
            fsm       <= RESP;
          end else begin
            tries <= tries + TRY_ONE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm       <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng.sv
// Testbench for lfsr_rng: two instances share stimulus, one with the
// default retry limit and one with MAX_TRIES=4. Expected responses come
// from a behavioural model of the generator and are queued per request.
module tb_lfsr_rng;

  logic       clk;
  logic       clr;
  logic       load;
  logic [7:0] seed;
  logic       en;
  logic       req_valid;
  logic [7:0] req_bound;
  logic       rsp_ready;

  logic       req_ready,  rsp_valid;
  logic [7:0] rsp_data,   state_out;
  logic       req_ready4, rsp_valid4;
  logic [7:0] rsp_data4,  state_out4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];
  logic [7:0] mstate, mstate4;
  logic [7:0] last_data, last_data4;
  int         last_lat, last_lat4;

  lfsr_rng dut (
    .clk(clk), .clr(clr), .load(load), .seed(seed), .en(en),
    .req_valid(req_valid), .req_bound(req_bound), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .state_out(state_out)
  );

  lfsr_rng #(.MAX_TRIES(4)) dut4 (
    .clk(clk), .clr(clr), .load(load), .seed(seed), .en(en),
    .req_valid(req_valid), .req_bound(req_bound), .req_ready(req_ready4),
    .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .rsp_ready(rsp_ready),
    .state_out(state_out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] m_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Behavioural draw: value, rejected-draw count and state after response.
  task automatic m_draw(input logic [7:0] s, input logic [7:0] b, input int max_tries,
                        output logic [7:0] val, output int k, output logic [7:0] s_after);
    logic [7:0] mask;
    logic [7:0] cand;
    mask = 8'h00;
    val  = 8'h00;
    k    = 0;
    if (b == 8'h00) begin
      val = s;
    end else if (b == 8'h01) begin
      val = 8'h00;
    end else begin
      while ({24'd0, mask} < ({24'd0, b} - 32'd1)) mask = {mask[6:0], 1'b1};
      for (int t = 0; t < max_tries; t++) begin
        cand = s & mask;
        if (cand < b) begin
          val = cand; k = t;
          break;
        end
        if (t == max_tries - 1) begin
          val = cand - b; k = t;
          break;
        end
        s = m_step(s);
      end
    end
    s_after = m_step(s);
  endtask

  task automatic load_both(input logic [7:0] s);
    seed = s;
    load = 1'b1;
    tick();
    load = 1'b0;
    mstate  = (s == 8'h00) ? 8'h01 : s;
    mstate4 = mstate;
  endtask

  task automatic do_request(input logic [7:0] b, input int hold);
    logic [7:0] e, e4, sa, sa4, ex;
    int k, k4, cyc;
    bit got, got4, ok;
    m_draw(mstate,  b, 8, e,  k,  sa);
    m_draw(mstate4, b, 4, e4, k4, sa4);
    exp_q.push_back(e);
    exp4_q.push_back(e4);
    n_tests++;
    if (req_ready !== 1'b1 || req_ready4 !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready_idle: got %b/%b expected 1/1", req_ready, req_ready4);
    end
    req_valid = 1'b1;
    req_bound = b;
    tick();
    req_valid = 1'b0;
    n_tests++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_edge: req_ready=%b rsp_valid=%b expected 0 0", req_ready, rsp_valid);
    end
    cyc = 0; got = 0; got4 = 0;
    last_lat = -1; last_lat4 = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      cyc++;
      if (!got && rsp_valid === 1'b1) begin
        got = 1; last_lat = cyc; last_data = rsp_data;
        ex = exp_q.pop_front();
        n_tests++;
        if (rsp_data !== ex) begin
          n_fail++;
          $display("FAIL rsp_data bound=%0d: got %h expected %h", b, rsp_data, ex);
        end
      end
      if (!got4 && rsp_valid4 === 1'b1) begin
        got4 = 1; last_lat4 = cyc; last_data4 = rsp_data4;
        ex = exp4_q.pop_front();
        n_tests++;
        if (rsp_data4 !== ex) begin
          n_fail++;
          $display("FAIL rsp_data4 bound=%0d: got %h expected %h", b, rsp_data4, ex);
        end
      end
      if (got && got4) break;
    end
    if (!got) begin
      n_tests++; n_fail++;
      ex = exp_q.pop_front();
      $display("FAIL rsp_timeout: no response, expected data %h", ex);
    end
    if (!got4) begin
      n_tests++; n_fail++;
      ex = exp4_q.pop_front();
      $display("FAIL rsp4_timeout: no response, expected data %h", ex);
    end
    n_tests++;
    if (last_lat != k + 1 || last_lat4 != k4 + 1) begin
      n_fail++;
      $display("FAIL latency bound=%0d: got %0d/%0d expected %0d/%0d", b, last_lat, last_lat4, k + 1, k4 + 1);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== last_data || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL resp_hold cyc %0d: valid=%b data=%h ready=%b expected 1 %h 0",
                 h, rsp_valid, rsp_data, req_ready, last_data);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid4 !== 1'b0 || req_ready4 !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_consume: valid=%b/%b ready=%b/%b expected 0/0 1/1",
               rsp_valid, rsp_valid4, req_ready, req_ready4);
    end
    n_tests++;
    if (state_out !== sa || state_out4 !== sa4) begin
      n_fail++;
      $display("FAIL state_after_draw: got %h/%h expected %h/%h", state_out, state_out4, sa, sa4);
    end
    mstate  = sa;
    mstate4 = sa4;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (state_out !== 8'h01 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: state=%h ready=%b valid=%b data=%h expected 01 1 0 00",
               state_out, req_ready, rsp_valid, rsp_data);
    end
    n_tests++;
    if (state_out4 !== 8'h01 || rsp_valid4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset4: state=%h valid=%b expected 01 0", state_out4, rsp_valid4);
    end
    clr = 1'b1;
    mstate = 8'h01; mstate4 = 8'h01;
  endtask

  task automatic test_step();
    int seen[256];
    int bad;
    logic [7:0] exp_seq[4];
    exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11};
    for (int v = 0; v < 256; v++) seen[v] = 0;
    en = 1'b1;
    for (int i = 0; i < 255; i++) begin
      seen[state_out]++;
      tick();
      if (i < 4) begin
        n_tests++;
        if (state_out !== exp_seq[i]) begin
          n_fail++;
          $display("FAIL step%0d: got %h expected %h", i + 1, state_out, exp_seq[i]);
        end
      end
    end
    en = 1'b0;
    n_tests++;
    if (state_out !== 8'h01 || state_out4 !== 8'h01) begin
      n_fail++;
      $display("FAIL period_return: got %h/%h expected 01", state_out, state_out4);
    end
    bad = (seen[0] != 0) ? 1 : 0;
    for (int v = 1; v < 256; v++) if (seen[v] != 1) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL period_coverage: got %0d irregular values expected 0", bad);
    end
  endtask

  task automatic test_load();
    load_both(8'h00);
    n_tests++;
    if (state_out !== 8'h01) begin
      n_fail++;
      $display("FAIL load_zero: got %h expected 01", state_out);
    end
    seed = 8'h5A; load = 1'b1; en = 1'b1;
    tick();
    load = 1'b0; en = 1'b0;
    n_tests++;
    if (state_out !== 8'h5A || state_out4 !== 8'h5A) begin
      n_fail++;
      $display("FAIL load_over_en: got %h/%h expected 5a", state_out, state_out4);
    end
    mstate = 8'h5A; mstate4 = 8'h5A;
  endtask

  task automatic test_first_draw();
    load_both(8'h01);
    do_request(8'd10, 0);
    n_tests++;
    if (last_data !== 8'h01 || last_lat != 1) begin
      n_fail++;
      $display("FAIL first_draw: data=%h lat=%0d expected 01 1", last_data, last_lat);
    end
  endtask

  task automatic test_reject();
    load_both(8'h0F);
    do_request(8'd10, 0);
    n_tests++;
    if (last_data !== 8'h06 || last_lat != 6) begin
      n_fail++;
      $display("FAIL reject_tries8: data=%h lat=%0d expected 06 6", last_data, last_lat);
    end
    n_tests++;
    if (last_data4 !== 8'h03 || last_lat4 != 4) begin
      n_fail++;
      $display("FAIL fallback_tries4: data=%h lat=%0d expected 03 4", last_data4, last_lat4);
    end
  endtask

  task automatic test_bound_edges();
    load_both(8'h11);
    do_request(8'd0, 5);
    n_tests++;
    if (last_data !== 8'h11) begin
      n_fail++;
      $display("FAIL bound0: got %h expected 11", last_data);
    end
    do_request(8'd1, 0);
    n_tests++;
    if (last_data !== 8'h00 || last_data4 !== 8'h00) begin
      n_fail++;
      $display("FAIL bound1: got %h/%h expected 00", last_data, last_data4);
    end
  endtask

  task automatic test_random();
    load_both(8'hC3);
    for (int i = 0; i < 8; i++) begin
      do_request(8'($urandom_range(2, 255)), i % 3);
    end
  endtask

  task automatic test_load_abort();
    bit spurious;
    load_both(8'h0F);
    req_valid = 1'b1; req_bound = 8'd10;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    seed = 8'h33; load = 1'b1;
    tick();
    load = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || state_out !== 8'h33 || state_out4 !== 8'h33) begin
      n_fail++;
      $display("FAIL load_abort: valid=%b ready=%b state=%h/%h expected 0 1 33/33",
               rsp_valid, req_ready, state_out, state_out4);
    end
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || rsp_valid4 !== 1'b0) spurious = 1;
    end
    n_tests++;
    if (spurious) begin
      n_fail++;
      $display("FAIL load_abort_quiet: got rsp_valid after abort expected none");
    end
    mstate = 8'h33; mstate4 = 8'h33;
  endtask

  task automatic test_clr_abort();
    load_both(8'h11);
    req_valid = 1'b1; req_bound = 8'd0;
    tick();
    req_valid = 1'b0;
    tick();
    n_tests++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_precond: rsp_valid got %b expected 1", rsp_valid);
    end
    clr = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || state_out !== 8'h01 || rsp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL clr_abort: valid=%b ready=%b state=%h data=%h expected 0 1 01 00",
               rsp_valid, req_ready, state_out, rsp_data);
    end
    tick();
    clr = 1'b1;
    tick();
    n_tests++;
    if (rsp_valid !== 1'b0 || state_out !== 8'h01 || rsp_valid4 !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_release: valid=%b state=%h expected 0 01", rsp_valid, state_out);
    end
    mstate = 8'h01; mstate4 = 8'h01;
  endtask

  initial begin
    clr = 1'b1; load = 1'b0; seed = 8'h00; en = 1'b0;
    req_valid = 1'b0; req_bound = 8'h00; rsp_ready = 1'b0;
    last_data = 8'h00; last_data4 = 8'h00; last_lat = 0; last_lat4 = 0;
    mstate = 8'h01; mstate4 = 8'h01;
    #2 clr = 1'b0;
    test_reset();
    test_step();
    test_load();
    test_first_draw();
    test_reject();
    test_bound_edges();
    test_random();
    test_load_abort();
    test_clr_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
